// File: rtl/fwd_scoreboard.sv
// Operand forwarding selects plus a one-entry multdiv scoreboard with load-use/multdiv stall.
// Latency: selects and stall are combinational (0 cycles); md_busy/md_rd update one edge after the event.
// Backpressure: stall freezes fetch/decode/execute; a multdiv start is only accepted when stall is low.
// Optional watchdog: define FWD_MD_WATCHDOG_EN to abort a multdiv op that exceeds MD_LAT cycles.
module fwd_scoreboard #(
    parameter int REG_AW = 5,
    parameter int MD_LAT = 34,
    parameter int CNT_W  = 6
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [REG_AW-1:0] x_rs1,
    input  logic [REG_AW-1:0] x_rs2,
    input  logic [REG_AW-1:0] x_rd,
    input  logic              x_we,
    input  logic              x_md_start,
    input  logic [REG_AW-1:0] m_rd,
    input  logic              m_we,
    input  logic              m_is_load,
    input  logic [REG_AW-1:0] w_rd,
    input  logic              w_we,
    input  logic              md_ready,
    output logic [1:0]        alu_a_sel,
    output logic [1:0]        alu_b_sel,
    output logic              stall,
    output logic              md_busy,
    output logic [REG_AW-1:0] md_rd,
    output logic              md_err
);

    // The busy counter must be able to represent MD_LAT before it saturates.
    if ((1 << CNT_W) <= MD_LAT) begin : g_cfg_check
        $error("fwd_scoreboard: CNT_W too narrow for MD_LAT");
    end

    localparam logic [1:0] SEL_MEM = 2'b00;
    localparam logic [1:0] SEL_WB  = 2'b01;
    localparam logic [1:0] SEL_RF  = 2'b10;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [REG_AW-1:0] md_rd_q, md_rd_d;
    logic              lu_haz;
    logic              md_haz;
    logic              md_raw;
    logic              md_waw;
    logic              md_accept;
    logic              wd_fire;

    // Memory stage wins over writeback; r0 and non-writing stages never forward.
    function automatic logic [1:0] fwd_sel(input logic [REG_AW-1:0] src);
        logic [1:0] sel;
        sel = SEL_RF;
        if (src == '0) begin
            sel = SEL_RF;
        end else if (m_we && (m_rd == src)) begin
            sel = SEL_MEM;
        end else if (w_we && (w_rd == src)) begin
            sel = SEL_WB;
        end
        return sel;
    endfunction

    // Operand selects and hazard detection, all zero-latency.
    always_comb begin
        alu_a_sel = fwd_sel(x_rs1);
        alu_b_sel = fwd_sel(x_rs2);
        lu_haz    = m_is_load && m_we && (m_rd != '0) &&
                    ((m_rd == x_rs1) || (m_rd == x_rs2));
        md_raw    = (md_rd_q != '0) && ((md_rd_q == x_rs1) || (md_rd_q == x_rs2));
        md_waw    = x_we && (x_rd == md_rd_q);
        // md_ready releases the hazard in the same cycle the result is written.
        md_haz    = (state_q == ST_BUSY) && !md_ready && (md_raw || md_waw || x_md_start);
        stall     = lu_haz || md_haz;
        md_accept = (state_q == ST_IDLE) && x_md_start && !stall;
    end

`ifdef FWD_MD_WATCHDOG_EN
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    // Counter reads k-1 in the k-th BUSY cycle, so this fires on the edge ending BUSY cycle MD_LAT.
    localparam logic [CNT_W-1:0] WD_LAST = CNT_W'(MD_LAT - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;

    assign wd_fire = (state_q == ST_BUSY) && !md_ready && (cnt_q == WD_LAST);
    assign md_err  = err_q;

    // Busy-cycle counter: cleared on accept, saturating count while BUSY; error is sticky.
    always_comb begin
        cnt_d = cnt_q;
        if (md_accept) begin
            cnt_d = '0;
        end else if ((state_q == ST_BUSY) && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
        err_d = err_q || wd_fire;
    end

    // Watchdog state registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end
`else
    // Without the watchdog an op stays pending until md_ready.
    assign wd_fire = 1'b0;
    assign md_err  = 1'b0;
`endif

    // Scoreboard state register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Scoreboard next state; md_ready in IDLE is ignored.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: if (md_accept) state_d = ST_BUSY;
            ST_BUSY: if (md_ready || wd_fire) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Scoreboard outputs decoded from the current state.
    always_comb begin
        md_busy = (state_q == ST_BUSY);
        md_rd   = md_rd_q;
    end

    // Pending destination: captured on accept, held after completion.
    always_comb begin
        md_rd_d = md_accept ? x_rd : md_rd_q;
    end

    // Pending destination register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            md_rd_q <= '0;
        end else begin
            md_rd_q <= md_rd_d;
        end
    end

endmodule

// File: tb/tb_fwd_scoreboard.sv
// Testbench for fwd_scoreboard: directed scenarios followed by random traffic.
// Expected responses come from a behavioural model and are queued; a monitor compares at negedge.
// Honours FWD_MD_WATCHDOG_EN in the model so either build can be checked.
module tb_fwd_scoreboard;
    localparam int AW  = 5;
    localparam int LAT = 34;
    localparam int CW  = 6;

    logic          clock = 1'b0;
    logic          reset;
    logic [AW-1:0] x_rs1, x_rs2, x_rd, m_rd, w_rd;
    logic          x_we, x_md_start, m_we, m_is_load, w_we, md_ready;
    logic [1:0]    alu_a_sel, alu_b_sel;
    logic          stall, md_busy, md_err;
    logic [AW-1:0] md_rd;

    fwd_scoreboard #(.REG_AW(AW), .MD_LAT(LAT), .CNT_W(CW)) dut (
        .clock(clock), .reset(reset),
        .x_rs1(x_rs1), .x_rs2(x_rs2), .x_rd(x_rd), .x_we(x_we), .x_md_start(x_md_start),
        .m_rd(m_rd), .m_we(m_we), .m_is_load(m_is_load),
        .w_rd(w_rd), .w_we(w_we), .md_ready(md_ready),
        .alu_a_sel(alu_a_sel), .alu_b_sel(alu_b_sel), .stall(stall),
        .md_busy(md_busy), .md_rd(md_rd), .md_err(md_err)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [AW-1:0] rs1, rs2, rd, mrd, wrd;
        logic xwe, start, mwe, mld, wwe, rdy;
    } stim_t;

    typedef struct {
        logic [1:0]    a, b;
        logic          stall, busy, err;
        logic [AW-1:0] rd;
        string         tag;
    } exp_t;

    exp_t  expq[$];
    int    checks   = 0;
    int    failures = 0;
    stim_t s;

    // Behavioural model: is an op pending, for which register, how many cycles so far.
    bit          mb_busy;
    logic [AW-1:0] mb_rd;
    int          mb_n;
    bit          mb_err;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [1:0] ref_sel(input logic [AW-1:0] src);
        if (src == 0) return 2'b10;
        if (m_we && m_rd == src) return 2'b00;
        if (w_we && w_rd == src) return 2'b01;
        return 2'b10;
    endfunction

    function automatic bit ref_stall();
        bit lu, md;
        lu = m_is_load && m_we && (m_rd != 0) && (m_rd == x_rs1 || m_rd == x_rs2);
        md = mb_busy && !md_ready &&
             (((mb_rd != 0) && (mb_rd == x_rs1 || mb_rd == x_rs2)) ||
              (x_we && x_rd == mb_rd) || x_md_start);
        return lu || md;
    endfunction

    function automatic void model_clear();
        mb_busy = 0; mb_rd = '0; mb_n = 0; mb_err = 0;
    endfunction

    // Advance the model across one clock edge using the inputs held during it.
    function automatic void model_edge();
        if (mb_busy) begin
            if (md_ready) mb_busy = 0;
`ifdef FWD_MD_WATCHDOG_EN
            else if (mb_n >= LAT) begin mb_err = 1; mb_busy = 0; end
`endif
            else mb_n++;
        end else if (x_md_start && !ref_stall()) begin
            mb_busy = 1; mb_rd = x_rd; mb_n = 1;
        end
    endfunction

    // One cycle: update model at the edge, apply new inputs, queue expected response.
    task automatic step(input stim_t st, input string tag);
        exp_t e;
        @(posedge clock);
        #1;
        model_edge();
        x_rs1 = st.rs1; x_rs2 = st.rs2; x_rd = st.rd; x_we = st.xwe; x_md_start = st.start;
        m_rd = st.mrd; m_we = st.mwe; m_is_load = st.mld;
        w_rd = st.wrd; w_we = st.wwe; md_ready = st.rdy;
        #1;
        e.a = ref_sel(x_rs1); e.b = ref_sel(x_rs2); e.stall = ref_stall();
        e.busy = mb_busy; e.rd = mb_rd; e.err = mb_err; e.tag = tag;
        expq.push_back(e);
    endtask

    // Monitor: compare DUT against queued expectations away from the rising edge.
    always @(negedge clock) begin
        exp_t e;
        if (expq.size() > 0) begin
            e = expq.pop_front();
            chk({e.tag, ".a_sel"}, 32'(alu_a_sel), 32'(e.a));
            chk({e.tag, ".b_sel"}, 32'(alu_b_sel), 32'(e.b));
            chk({e.tag, ".stall"}, 32'(stall),     32'(e.stall));
            chk({e.tag, ".busy"},  32'(md_busy),   32'(e.busy));
            chk({e.tag, ".md_rd"}, 32'(md_rd),     32'(e.rd));
            chk({e.tag, ".err"},   32'(md_err),    32'(e.err));
        end
    end

    initial begin
        reset = 1'b1;
        x_rs1 = '0; x_rs2 = '0; x_rd = '0; x_we = 0; x_md_start = 0;
        m_rd = '0; m_we = 0; m_is_load = 0; w_rd = '0; w_we = 0; md_ready = 0;
        model_clear();
        #2;
        chk("rst.busy",  32'(md_busy),   32'd0);
        chk("rst.md_rd", 32'(md_rd),     32'd0);
        chk("rst.err",   32'(md_err),    32'd0);
        chk("rst.stall", 32'(stall),     32'd0);
        chk("rst.a_sel", 32'(alu_a_sel), 32'd2);
        #5 reset = 1'b0;

        // Forwarding priority
        s = '0; s.rs1 = 5; s.mrd = 5; s.mwe = 1; s.wrd = 5; s.wwe = 1; step(s, "fwd_mem");
        s.mwe = 0; step(s, "fwd_wb");
        s.wwe = 0; step(s, "fwd_rf");
        // r0 and write-enable qualification
        s = '0; s.rs2 = 0; s.mrd = 0; s.mwe = 1; step(s, "fwd_r0");
        s = '0; s.rs2 = 7; s.wrd = 7; step(s, "fwd_we0");
        // Load-use
        s = '0; s.mld = 1; s.mwe = 1; s.mrd = 3; s.rs2 = 3; step(s, "lu_on");
        s.mld = 0; step(s, "lu_off");
        // Multdiv RAW
        s = '0; s.start = 1; s.rd = 9; s.xwe = 1; step(s, "md_issue");
        s = '0; s.rs1 = 9; repeat (10) step(s, "md_raw");
        s.rdy = 1; step(s, "md_rdy");
        s.rdy = 0; step(s, "md_done");
        // Structural hazard and simultaneous ready/start
        s = '0; s.start = 1; s.rd = 4; step(s, "st_issue");
        step(s, "st_struct");
        s.rdy = 1; step(s, "st_both");
        s.rdy = 0; step(s, "st_accept");
        s = '0; step(s, "st_busy");
        s.rdy = 1; step(s, "st_rdy");
        s = '0; step(s, "st_idle");
        // Long op without md_ready: held pending, or aborted by the watchdog
        s = '0; s.start = 1; s.rd = 12; step(s, "wd_issue");
        s = '0; repeat (100) step(s, "wd_hold");
        // Asynchronous reset mid-cycle, with no edge in between
        @(negedge clock);
        #1 reset = 1'b1;
        #1;
        chk("arst.busy",  32'(md_busy), 32'd0);
        chk("arst.md_rd", 32'(md_rd),   32'd0);
        chk("arst.err",   32'(md_err),  32'd0);
        model_clear();
        #1 reset = 1'b0;

        // Random traffic over a small register range to provoke matches
        repeat (3000) begin
            s.rs1   = AW'($urandom_range(0, 7));
            s.rs2   = AW'($urandom_range(0, 7));
            s.rd    = AW'($urandom_range(0, 7));
            s.mrd   = AW'($urandom_range(0, 7));
            s.wrd   = AW'($urandom_range(0, 7));
            s.xwe   = 1'($urandom_range(0, 1));
            s.mwe   = 1'($urandom_range(0, 1));
            s.wwe   = 1'($urandom_range(0, 1));
            s.mld   = ($urandom_range(0, 3) == 0);
            s.start = ($urandom_range(0, 3) == 0);
            s.rdy   = ($urandom_range(0, 5) == 0);
            step(s, "rand");
        end
        s = '0; step(s, "final");
        @(negedge clock);
        #1;
        chk("queue_drained", 32'(expq.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
